prbs_checker: RTL and testbench
===============================

Name: prbs_checker

Overview:
- Serial PRBS checker that sits directly downstream of the registered flop-to-flop data path and consumes its 1-bit output stream.
- Self-synchronises a local LFSR to the incoming bits, then flags every mismatch and counts errors.
- Drops lock on excessive errors.
- Used on-silicon to prove the flop-to-flop path passes data correctly at speed.

Parameters:
- LFSR_W, 7: LFSR length (PRBS7).
- TAP_MASK, 7'h60: feedback taps. fb = XOR of state bits selected by mask; default is x^7+x^6+1.
- LOCK_CNT, 16: consecutive correct predictions required to lock.
- WIN_LEN, 64: error-monitor window length in valid bits.
- LOSS_THRESH, 8: errors within one window that force loss of lock.
- CNT_W, 16: width of err_cnt.

Ports:
- clk  in  1  sole clock; all state on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- din_valid  in  1  din carries a new bit this cycle.
- din  in  1  serial data from the upstream flop pair.
- clr_cnt  in  1  synchronous clear of err_cnt and bit_cnt.
- locked  out  1  checker synchronised.
- err_pulse  out  1  one-cycle strobe per mismatched bit while locked.
- err_cnt  out  CNT_W  saturating error count.
- bit_cnt  out  32  saturating count of valid bits checked while locked.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high. Reset clears state, lfsr, fill_cnt, match_cnt, win_cnt and win_err to 0. Outputs reset to locked=0, err_pulse=0, err_cnt=0, bit_cnt=0.
- Idle cycles: nothing advances when din_valid=0; err_pulse=0 on those cycles.
- Prediction: exp = fb(lfsr), evaluated each valid cycle.
- HUNT state:
  - Load: lfsr <= {lfsr[LFSR_W-2:0], din}.
  - Seed fill: the first LFSR_W valid bits after entering HUNT only fill the register (fill_cnt) and are not compared.
  - Matching: after fill, match_cnt increments when din==exp and clears when din!=exp.
  - All-zero guard: match_cnt also clears when the pre-shift lfsr is all zeros.
  - Lock: when match_cnt reaches LOCK_CNT, go to LOCKED. locked=1 from the following cycle.
  - No counting: no err_pulse and no counting in HUNT.
- LOCKED state:
  - Free-run: lfsr <= {lfsr[LFSR_W-2:0], exp}, independent of din.
  - Bit count: bit_cnt increments per valid bit, saturating at 2^32-1.
  - On mismatch: err_pulse=1 in the cycle after the bit is sampled (registered, latency 1). err_cnt increments, saturating at 2^CNT_W-1 with no wrap.
- Error window:
  - win_cnt counts valid bits 0..WIN_LEN-1; win_err counts errors within the window.
  - Both restart at window end. When the final bit of a window is itself an error, the new window starts with win_err=0.
- Loss of lock:
  - When win_err would reach LOSS_THRESH, go to HUNT and deassert locked the next cycle.
  - The error that causes loss is still pulsed and counted.
  - fill_cnt, match_cnt, win_cnt and win_err clear. err_cnt and bit_cnt hold.
- clr_cnt: sets err_cnt and bit_cnt to 0 and has priority over a same-cycle increment, so that cycle's error is not counted. err_pulse still fires. Lock state is unaffected.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); re-lock requires a full fill plus LOCK_CNT matches.

Decomposition:
- Package prbs_pkg: state enum {HUNT, LOCKED}; default PRBS7 constants (LFSR_W, TAP_MASK); PRBS15 constants (15, 15'h6000) for reuse.
- Sub-module prbs_lfsr: combinational. Inputs: state vector, TAP_MASK, load-bit, load-select. Outputs: fb and next state. Shared with the matching upstream generator.

Test Plan:
- Reset: assert rst asynchronously mid-cycle → locked=0, err_pulse=0, err_cnt=0, bit_cnt=0 without waiting for a clk edge.
- Clean lock: PRBS7 from seed 7'h7F, din_valid=1 continuously.
  - locked=1 on the cycle after the 23rd bit (7 fill + 16 matches).
  - After 1000 further bits: err_cnt=0, bit_cnt=1000.
- Gapped valid: the same stream with din_valid toggling 1/0 → identical lock point counted in valid bits, and no err_pulse on idle cycles.
- Single error: flip locked-stream bit 100 → exactly one err_pulse, one cycle after that bit; err_cnt=1; locked stays 1.
- Stuck input: din=0 constant, 500 valid cycles → locked never asserts (all-zero guard).
- Loss and clear:
  - Invert din after lock → err_pulse on 8 consecutive valid bits, err_cnt=8, locked=0 the cycle after the 8th error.
  - Then clr_cnt in the same cycle as a new locked-state error → err_cnt=0.

Source files
------------

// File: rtl/prbs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : prbs_pkg                                                     |
// | Description : Shared types and LFSR constants for the PRBS checker and the |
// |               matching upstream pattern generator.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package prbs_pkg;

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // PRBS7: x^7 + x^6 + 1
  localparam int          PRBS7_LFSR_W    = 7;
  localparam logic [6:0]  PRBS7_TAP_MASK  = 7'h60;

  // PRBS15: x^15 + x^14 + 1
  localparam int          PRBS15_LFSR_W   = 15;
  localparam logic [14:0] PRBS15_TAP_MASK = 15'h6000;

endpackage : prbs_pkg
`default_nettype wire

// File: rtl/prbs_checker_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : prbs_checker_if                                              |
// | Description : Serial data input, counter clear and status outputs of the   |
// |               PRBS checker.                                                |
// |   din_valid / din / clr_cnt : driven by master (data path / host)          |
// |   locked / err_pulse        : checker status                               |
// |   err_cnt [CNT_W] / bit_cnt [32] : saturating counters                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface prbs_checker_if #(
  parameter int CNT_W = 16
) ();

  logic             din_valid;
  logic             din;
  logic             clr_cnt;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_cnt;
  logic [31:0]      bit_cnt;

  modport master (
    output din_valid, din, clr_cnt,
    input  locked, err_pulse, err_cnt, bit_cnt
  );

  modport slave (
    input  din_valid, din, clr_cnt,
    output locked, err_pulse, err_cnt, bit_cnt
  );

endinterface : prbs_checker_if
`default_nettype wire

// File: rtl/prbs_lfsr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : prbs_lfsr                                                    |
// | Description : Combinational Fibonacci LFSR step. Feedback is the XOR of    |
// |               the state bits selected by mask_i; the new LSB is either the |
// |               feedback (free-run) or an external bit (load).               |
// |   state_i [W]  current state       mask_i [W]   feedback taps              |
// |   load_bit_i   external bit        load_sel_i   1 = shift in load_bit_i    |
// |   fb_o         feedback bit        next_o [W]   next state                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module prbs_lfsr #(
  parameter int W = 7
) (
  input  logic [W-1:0] state_i,
  input  logic [W-1:0] mask_i,
  input  logic         load_bit_i,
  input  logic         load_sel_i,
  output logic         fb_o,
  output logic [W-1:0] next_o
);

  assign fb_o   = ^(state_i & mask_i);
  assign next_o = {state_i[W-2:0], (load_sel_i ? load_bit_i : fb_o)};

endmodule : prbs_lfsr
`default_nettype wire

// File: rtl/prbs_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : prbs_checker                                                 |
// | Description : Self-synchronising serial PRBS checker. In HUNT the local    |
// |               LFSR is loaded from the incoming bits until LOCK_CNT         |
// |               consecutive predictions hit; in LOCKED it free-runs, flags   |
// |               each mismatch with a registered strobe and counts errors.    |
// |               LOSS_THRESH errors inside one WIN_LEN-bit window drop lock.  |
// |   clk, rst (async, active-high)                                            |
// |   chk : prbs_checker_if.slave (din_valid, din, clr_cnt -> locked,          |
// |         err_pulse, err_cnt, bit_cnt)                                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int                LFSR_W      = PRBS7_LFSR_W,
  parameter logic [LFSR_W-1:0] TAP_MASK    = PRBS7_TAP_MASK,
  parameter int                LOCK_CNT    = 16,
  parameter int                WIN_LEN     = 64,
  parameter int                LOSS_THRESH = 8,
  parameter int                CNT_W       = 16
) (
  input  logic          clk,
  input  logic          rst,
  prbs_checker_if.slave chk
);

  localparam int FILL_W  = $clog2(LFSR_W + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT);
  localparam int WIN_W   = $clog2(WIN_LEN);
  localparam int WERR_W  = $clog2(LOSS_THRESH);

  localparam logic [FILL_W-1:0]  FILL_DONE  = FILL_W'(LFSR_W);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
  localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WIN_LEN - 1);
  localparam logic [WERR_W-1:0]  WERR_LAST  = WERR_W'(LOSS_THRESH - 1);

  state_e              state_q,     state_d;
  logic [LFSR_W-1:0]   lfsr_q,      lfsr_d;
  logic [FILL_W-1:0]   fill_cnt_q,  fill_cnt_d;
  logic [MATCH_W-1:0]  match_cnt_q, match_cnt_d;
  logic [WIN_W-1:0]    win_cnt_q,   win_cnt_d;
  logic [WERR_W-1:0]   win_err_q,   win_err_d;
  logic                err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0]    err_cnt_q,   err_cnt_d;
  logic [31:0]         bit_cnt_q,   bit_cnt_d;

  logic                lfsr_fb;
  logic [LFSR_W-1:0]   lfsr_next;
  logic                mismatch;

  // HUNT shifts the received bit in; LOCKED shifts the prediction in.
  prbs_lfsr #(
    .W (LFSR_W)
  ) u_lfsr (
    .state_i    (lfsr_q),
    .mask_i     (TAP_MASK),
    .load_bit_i (chk.din),
    .load_sel_i (state_q == HUNT),
    .fb_o       (lfsr_fb),
    .next_o     (lfsr_next)
  );

  assign mismatch = chk.din ^ lfsr_fb;

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    fill_cnt_d  = fill_cnt_q;
    match_cnt_d = match_cnt_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    bit_cnt_d   = bit_cnt_q;

    if (chk.din_valid) begin
      lfsr_d = lfsr_next;
      if (state_q == HUNT) begin
        if (fill_cnt_q != FILL_DONE) begin
          fill_cnt_d = fill_cnt_q + FILL_W'(1);
        end else if (!mismatch && (lfsr_q != '0)) begin
          // An all-zero register predicts zeros forever; never lock on it.
          if (match_cnt_q == MATCH_LAST) begin
            state_d     = LOCKED;
            fill_cnt_d  = '0;
            match_cnt_d = '0;
            win_cnt_d   = '0;
            win_err_d   = '0;
          end else begin
            match_cnt_d = match_cnt_q + MATCH_W'(1);
          end
        end else begin
          match_cnt_d = '0;
        end
      end else begin
        if (bit_cnt_q != '1) begin
          bit_cnt_d = bit_cnt_q + 32'd1;
        end
        if (mismatch) begin
          err_pulse_d = 1'b1;
          if (err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
          end
        end
        // Loss is judged before the window wrap, so an error on the last
        // bit of a window can still trip it.
        if (mismatch && (win_err_q == WERR_LAST)) begin
          state_d     = HUNT;
          fill_cnt_d  = '0;
          match_cnt_d = '0;
          win_cnt_d   = '0;
          win_err_d   = '0;
        end else if (win_cnt_q == WIN_LAST) begin
          win_cnt_d = '0;
          win_err_d = '0;
        end else begin
          win_cnt_d = win_cnt_q + WIN_W'(1);
          win_err_d = win_err_q + WERR_W'(mismatch);
        end
      end
    end

    // Clear wins over any same-cycle increment.
    if (chk.clr_cnt) begin
      err_cnt_d = '0;
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      lfsr_q      <= '0;
      fill_cnt_q  <= '0;
      match_cnt_q <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
      bit_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      fill_cnt_q  <= fill_cnt_d;
      match_cnt_q <= match_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  assign chk.locked    = (state_q == LOCKED);
  assign chk.err_pulse = err_pulse_q;
  assign chk.err_cnt   = err_cnt_q;
  assign chk.bit_cnt   = bit_cnt_q;

endmodule : prbs_checker
`default_nettype wire

// File: tb/tb_prbs_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_prbs_checker                                              |
// | Description : Self-checking bench for prbs_checker. PRBS7 reference model  |
// |               works on the bit sequence (a[n] = a[n-7] ^ a[n-6]) rather    |
// |               than on a register image.                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_prbs_checker;

  logic clk = 1'b0;
  logic rst;

  prbs_checker_if #(.CNT_W(16)) bus ();

  prbs_checker dut (
    .clk (clk),
    .rst (rst),
    .chk (bus)
  );

  always #5 clk = ~clk;

  int n_pass;
  int n_checks;

  // Upstream PRBS7 generator state.
  logic [6:0] g;

  // Reference model state.
  bit     m_h[$];     // last 7 reference bits, oldest first
  bit     m_locked;
  int     m_fill;
  int     m_match;
  int     m_win;      // bits seen in current window (1..64)
  int     m_werr;
  int     m_errs;
  longint m_bits;
  bit     m_pulse;

  task automatic gen_next(output bit b);
    b = g[6] ^ g[5];
    g = {g[5:0], b};
  endtask

  task automatic model_reset();
    m_h.delete();
    repeat (7) m_h.push_back(1'b0);
    m_locked = 0; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0;
    m_errs = 0; m_bits = 0; m_pulse = 0;
  endtask

  task automatic model_step(input bit v, input bit d, input bit c);
    bit pred, err, allz;
    m_pulse = 0;
    if (v) begin
      pred = m_h[0] ^ m_h[1];
      allz = 1;
      foreach (m_h[i]) if (m_h[i]) allz = 0;
      err = (d != pred);
      if (!m_locked) begin
        if (m_fill < 7) m_fill++;
        else if (!err && !allz) begin
          m_match++;
          if (m_match == 16) begin
            m_locked = 1; m_match = 0; m_fill = 0; m_win = 0; m_werr = 0;
          end
        end else m_match = 0;
        m_h.push_back(d);
      end else begin
        m_h.push_back(pred);
        if (m_bits != 64'hFFFF_FFFF) m_bits++;
        if (err) begin
          m_pulse = 1;
          if (m_errs != 65535) m_errs++;
          m_werr++;
        end
        m_win++;
        if (m_werr == 8) begin
          m_locked = 0; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0;
        end else if (m_win == 64) begin
          m_win = 0; m_werr = 0;
        end
      end
      void'(m_h.pop_front());
    end
    if (c) begin
      m_errs = 0; m_bits = 0;
    end
  endtask

  // Drive one cycle; returns 1 time unit after the sampling edge.
  task automatic step(input bit v, input bit d, input bit c);
    bus.din_valid = v;
    bus.din       = d;
    bus.clr_cnt   = c;
    model_step(v, d, c);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.din_valid = 0; bus.din = 0; bus.clr_cnt = 0;
    rst = 1'b1;
    model_reset();
    g = 7'h7F;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic lock_up();
    bit b;
    for (int k = 1; k <= 23; k++) begin
      gen_next(b);
      step(1, b, 0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.din_valid = 0; bus.din = 0; bus.clr_cnt = 0;
    model_reset();
    g = 7'h7F;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.locked !== 1'b0) $display("FAIL reset_locked got=%b exp=0", bus.locked); else n_pass++;
    n_checks++; if (bus.err_pulse !== 1'b0) $display("FAIL reset_err_pulse got=%b exp=0", bus.err_pulse); else n_pass++;
    n_checks++; if (bus.err_cnt !== 16'd0) $display("FAIL reset_err_cnt got=%0d exp=0", bus.err_cnt); else n_pass++;
    n_checks++; if (bus.bit_cnt !== 32'd0) $display("FAIL reset_bit_cnt got=%0d exp=0", bus.bit_cnt); else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_clean_lock();
    bit b;
    int lock_at = 0;
    do_reset();
    for (int k = 1; k <= 1023; k++) begin
      gen_next(b);
      step(1, b, 0);
      if (bus.locked === 1'b1 && lock_at == 0) lock_at = k;
      n_checks++; if (bus.err_pulse !== 1'b0) $display("FAIL clean_pulse bit=%0d got=%b exp=0", k, bus.err_pulse); else n_pass++;
    end
    n_checks++; if (lock_at != 23) $display("FAIL clean_lock_point got=%0d exp=23", lock_at); else n_pass++;
    n_checks++; if (bus.locked !== 1'b1) $display("FAIL clean_locked got=%b exp=1", bus.locked); else n_pass++;
    n_checks++; if (bus.err_cnt !== 16'd0) $display("FAIL clean_err_cnt got=%0d exp=0", bus.err_cnt); else n_pass++;
    n_checks++; if (bus.bit_cnt !== 32'd1000) $display("FAIL clean_bit_cnt got=%0d exp=1000", bus.bit_cnt); else n_pass++;
  endtask

  task automatic test_gapped();
    bit b, v;
    int vcount = 0;
    int lock_at = 0;
    do_reset();
    for (int cyc = 0; cyc < 600 && vcount < 73; cyc++) begin
      v = 1'($urandom);
      if (v) begin
        gen_next(b);
        step(1, b, 0);
        vcount++;
      end else begin
        step(0, 1'($urandom), 0);
      end
      if (bus.locked === 1'b1 && lock_at == 0) lock_at = vcount;
      n_checks++; if (bus.err_pulse !== 1'b0) $display("FAIL gap_pulse cyc=%0d got=%b exp=0", cyc, bus.err_pulse); else n_pass++;
    end
    n_checks++; if (vcount != 73) $display("FAIL gap_timeout got=%0d exp=73", vcount); else n_pass++;
    n_checks++; if (lock_at != 23) $display("FAIL gap_lock_point got=%0d exp=23", lock_at); else n_pass++;
    n_checks++; if (bus.bit_cnt !== 32'd50) $display("FAIL gap_bit_cnt got=%0d exp=50", bus.bit_cnt); else n_pass++;
  endtask

  task automatic test_single_error();
    bit b;
    do_reset();
    lock_up();
    for (int k = 1; k <= 150; k++) begin
      gen_next(b);
      step(1, (k == 100) ? ~b : b, 0);
      n_checks++; if (bus.err_pulse !== (k == 100)) $display("FAIL single_pulse bit=%0d got=%b exp=%b", k, bus.err_pulse, (k == 100)); else n_pass++;
    end
    n_checks++; if (bus.err_cnt !== 16'd1) $display("FAIL single_err_cnt got=%0d exp=1", bus.err_cnt); else n_pass++;
    n_checks++; if (bus.locked !== 1'b1) $display("FAIL single_locked got=%b exp=1", bus.locked); else n_pass++;
    n_checks++; if (bus.bit_cnt !== 32'd150) $display("FAIL single_bit_cnt got=%0d exp=150", bus.bit_cnt); else n_pass++;
  endtask

  task automatic test_async_reset();
    bit b;
    #3;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.locked !== 1'b0) $display("FAIL areset_locked got=%b exp=0", bus.locked); else n_pass++;
    n_checks++; if (bus.err_pulse !== 1'b0) $display("FAIL areset_err_pulse got=%b exp=0", bus.err_pulse); else n_pass++;
    n_checks++; if (bus.err_cnt !== 16'd0) $display("FAIL areset_err_cnt got=%0d exp=0", bus.err_cnt); else n_pass++;
    n_checks++; if (bus.bit_cnt !== 32'd0) $display("FAIL areset_bit_cnt got=%0d exp=0", bus.bit_cnt); else n_pass++;
    bus.din_valid = 0;
    model_reset();
    g = 7'h7F;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      gen_next(b);
      step(1, b, 0);
      n_checks++; if (bus.locked !== (k >= 23)) $display("FAIL areset_relock bit=%0d got=%b exp=%b", k, bus.locked, (k >= 23)); else n_pass++;
    end
  endtask

  task automatic test_stuck();
    bit seen = 0;
    do_reset();
    for (int k = 0; k < 500; k++) begin
      step(1, 1'b0, 0);
      if (bus.locked !== 1'b0) seen = 1;
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL stuck_locked got=%b exp=0", seen); else n_pass++;
    n_checks++; if (bus.bit_cnt !== 32'd0) $display("FAIL stuck_bit_cnt got=%0d exp=0", bus.bit_cnt); else n_pass++;
  endtask

  task automatic test_window();
    bit b, is_err;
    int errs[15] = '{5, 10, 15, 20, 25, 30, 64, 70, 75, 80, 85, 90, 95, 100, 110};
    do_reset();
    lock_up();
    for (int k = 1; k <= 110; k++) begin
      gen_next(b);
      is_err = 0;
      foreach (errs[i]) if (errs[i] == k) is_err = 1;
      step(1, is_err ? ~b : b, 0);
      n_checks++; if (bus.err_pulse !== is_err) $display("FAIL win_pulse bit=%0d got=%b exp=%b", k, bus.err_pulse, is_err); else n_pass++;
      n_checks++; if (bus.locked !== (k < 110)) $display("FAIL win_locked bit=%0d got=%b exp=%b", k, bus.locked, (k < 110)); else n_pass++;
    end
    n_checks++; if (bus.err_cnt !== 16'd15) $display("FAIL win_err_cnt got=%0d exp=15", bus.err_cnt); else n_pass++;
    n_checks++; if (bus.bit_cnt !== 32'd110) $display("FAIL win_bit_cnt got=%0d exp=110", bus.bit_cnt); else n_pass++;
  endtask

  task automatic test_loss_and_clear();
    bit b;
    do_reset();
    lock_up();
    for (int k = 1; k <= 8; k++) begin
      gen_next(b);
      step(1, ~b, 0);
      n_checks++; if (bus.err_pulse !== 1'b1) $display("FAIL loss_pulse bit=%0d got=%b exp=1", k, bus.err_pulse); else n_pass++;
      n_checks++; if (bus.locked !== (k < 8)) $display("FAIL loss_locked bit=%0d got=%b exp=%b", k, bus.locked, (k < 8)); else n_pass++;
    end
    n_checks++; if (bus.err_cnt !== 16'd8) $display("FAIL loss_err_cnt got=%0d exp=8", bus.err_cnt); else n_pass++;
    for (int k = 1; k <= 23; k++) begin
      gen_next(b);
      step(1, b, 0);
      n_checks++; if (bus.locked !== (k == 23)) $display("FAIL loss_relock bit=%0d got=%b exp=%b", k, bus.locked, (k == 23)); else n_pass++;
    end
    n_checks++; if (bus.err_cnt !== 16'd8) $display("FAIL loss_hold_err_cnt got=%0d exp=8", bus.err_cnt); else n_pass++;
    gen_next(b);
    step(1, ~b, 1);
    n_checks++; if (bus.err_pulse !== 1'b1) $display("FAIL clr_pulse got=%b exp=1", bus.err_pulse); else n_pass++;
    n_checks++; if (bus.err_cnt !== 16'd0) $display("FAIL clr_err_cnt got=%0d exp=0", bus.err_cnt); else n_pass++;
    n_checks++; if (bus.bit_cnt !== 32'd0) $display("FAIL clr_bit_cnt got=%0d exp=0", bus.bit_cnt); else n_pass++;
    n_checks++; if (bus.locked !== 1'b1) $display("FAIL clr_locked got=%b exp=1", bus.locked); else n_pass++;
    gen_next(b);
    step(1, ~b, 0);
    n_checks++; if (bus.err_cnt !== 16'd1) $display("FAIL clr_then_err_cnt got=%0d exp=1", bus.err_cnt); else n_pass++;
    n_checks++; if (bus.bit_cnt !== 32'd1) $display("FAIL clr_then_bit_cnt got=%0d exp=1", bus.bit_cnt); else n_pass++;
  endtask

  task automatic test_random();
    bit b, d, v, c;
    int burst = 0;
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 299) == 0);
      if (v) begin
        gen_next(b);
        d = b;
        if (burst > 0) begin
          d = ~b;
          burst--;
        end else if ($urandom_range(0, 399) == 0) begin
          burst = $urandom_range(4, 12);
        end else if ($urandom_range(0, 49) == 0) begin
          d = ~b;
        end
      end else begin
        d = 1'($urandom);
      end
      step(v, d, c);
      n_checks++; if (bus.locked !== m_locked) $display("FAIL rnd_locked cyc=%0d got=%b exp=%b", cyc, bus.locked, m_locked); else n_pass++;
      n_checks++; if (bus.err_pulse !== m_pulse) $display("FAIL rnd_pulse cyc=%0d got=%b exp=%b", cyc, bus.err_pulse, m_pulse); else n_pass++;
      n_checks++; if (bus.err_cnt !== 16'(m_errs)) $display("FAIL rnd_err_cnt cyc=%0d got=%0d exp=%0d", cyc, bus.err_cnt, m_errs); else n_pass++;
      n_checks++; if (bus.bit_cnt !== 32'(m_bits)) $display("FAIL rnd_bit_cnt cyc=%0d got=%0d exp=%0d", cyc, bus.bit_cnt, m_bits); else n_pass++;
    end
  endtask

  initial begin
    n_pass   = 0;
    n_checks = 0;
    test_reset();
    test_clean_lock();
    test_gapped();
    test_single_error();
    test_async_reset();
    test_stuck();
    test_window();
    test_loss_and_clear();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_prbs_checker
`default_nettype wire
